// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/branch/multiply/memory-wait
// stall and flush generation, with a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rs1_E,
    input  logic [4:0]  rs2_E,
    input  logic [4:0]  rd_E,
    input  logic        memread_E,
    input  logic        regwrite_E,
    input  logic        mul_start_E,
    input  logic        branch_E,
    input  logic [4:0]  rd_M,
    input  logic        regwrite_M,
    input  logic [4:0]  rd_W,
    input  logic        regwrite_W,
    input  logic        mem_busy_M,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_F,
    output logic        flush_E,
    output logic        flush_M,
    output logic        flush_W,
    output logic [1:0]  fwdA_E,
    output logic [1:0]  fwdB_E,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {
        RUN = 2'd0,
        MUL = 2'd1,
        MEM = 2'd2
    } state_t;

    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

    state_t      state_q, state_n, saved_q, saved_n, eff_state;
    logic [3:0]  cnt_q, cnt_n;
    logic [15:0] stall_cnt_q;
    logic        load_use;
    logic        unused_regwrite_e;

    assign unused_regwrite_e = regwrite_E;
    assign state             = state_q;
    assign stall_cnt         = stall_cnt_q;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m,
                                           input logic [4:0] rd_m,
                                           input logic       wr_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            sel = 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        fwdA_E = 2'b00;
        fwdB_E = 2'b00;
        if (!rst) begin
            fwdA_E = fwd_sel(rs1_E, regwrite_M, rd_M, regwrite_W, rd_W);
            fwdB_E = fwd_sel(rs2_E, regwrite_M, rd_M, regwrite_W, rd_W);
        end
    end

    always_comb begin
        stall_F   = 1'b0;
        stall_D   = 1'b0;
        stall_E   = 1'b0;
        stall_M   = 1'b0;
        flush_F   = 1'b0;
        flush_E   = 1'b0;
        flush_M   = 1'b0;
        flush_W   = 1'b0;
        state_n   = RUN;
        saved_n   = saved_q;
        cnt_n     = cnt_q;
        // Leaving MEM behaves exactly like the state that was interrupted.
        eff_state = (state_q == MEM) ? saved_q : state_q;
        load_use  = memread_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

        if (rst) begin
            flush_F = 1'b1;
            flush_E = 1'b1;
            flush_M = 1'b1;
            flush_W = 1'b1;
            saved_n = RUN;
            cnt_n   = 4'd0;
        end else if (mem_busy_M) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
            state_n = MEM;
            saved_n = (state_q == MEM) ? saved_q : state_q;
        end else if (eff_state == MUL) begin
            if (cnt_q != 4'd0) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                flush_M = 1'b1;
                cnt_n   = cnt_q - 4'd1;
                state_n = MUL;
            end
        end else if (branch_E) begin
            flush_F = 1'b1;
            flush_E = 1'b1;
        end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end else if (mul_start_E) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            flush_M = 1'b1;
            cnt_n   = MUL_INIT;
            state_n = MUL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_n;
            saved_q <= saved_n;
            cnt_q   <= cnt_n;
            if (stall_D && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int MUL_LAT = 4;

    logic        clk, rst;
    logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic        memread_E, regwrite_E, mul_start_E, branch_E;
    logic        regwrite_M, regwrite_W, mem_busy_M;
    logic        stall_F, stall_D, stall_E, stall_M;
    logic        flush_F, flush_E, flush_M, flush_W;
    logic [1:0]  fwdA_E, fwdB_E, state;
    logic [15:0] stall_cnt;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .memread_E(memread_E), .regwrite_E(regwrite_E), .mul_start_E(mul_start_E),
        .branch_E(branch_E), .rd_M(rd_M), .regwrite_M(regwrite_M),
        .rd_W(rd_W), .regwrite_W(regwrite_W), .mem_busy_M(mem_busy_M),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_F(flush_F), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .state(state), .stall_cnt(stall_cnt)
    );

    assign ctl = {stall_F, stall_D, stall_E, stall_M, flush_F, flush_E, flush_M, flush_W};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: mode 0 run, 1 multiplying, 2 waiting on memory.
    int          m_mode = 0, m_saved = 0, m_left = 0, m_eff;
    logic [15:0] m_sc = 16'd0;
    logic        m_lu;
    logic [7:0]  exp_ctl;
    logic [1:0]  exp_fwdA, exp_fwdB;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regwrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
        if (regwrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        m_eff = (m_mode == 2) ? m_saved : m_mode;
        m_lu  = memread_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
        exp_fwdA = rst ? 2'b00 : ref_fwd(rs1_E);
        exp_fwdB = rst ? 2'b00 : ref_fwd(rs2_E);
        if (rst)                        exp_ctl = 8'b0000_1111;
        else if (mem_busy_M)            exp_ctl = 8'b1111_0001;
        else if (m_eff == 1)            exp_ctl = (m_left > 0) ? 8'b1110_0010 : 8'b0000_0000;
        else if (branch_E)              exp_ctl = 8'b0000_1100;
        else if (m_lu)                  exp_ctl = 8'b1100_0100;
        else if (mul_start_E)           exp_ctl = 8'b1110_0010;
        else                            exp_ctl = 8'b0000_0000;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= 0; m_saved <= 0; m_left <= 0; m_sc <= 16'd0;
        end else begin
            if (exp_ctl[6] && m_sc != 16'hFFFF) m_sc <= m_sc + 16'd1;
            if (mem_busy_M) begin
                if (m_mode != 2) m_saved <= m_mode;
                m_mode <= 2;
            end else if (m_eff == 1) begin
                if (m_left > 0) begin
                    m_left <= m_left - 1;
                    m_mode <= 1;
                end else begin
                    m_mode <= 0;
                end
            end else if (!branch_E && !m_lu && mul_start_E) begin
                m_mode <= 1;
                m_left <= MUL_LAT - 1;
            end else begin
                m_mode <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        memread_E = 0; regwrite_E = 0; mul_start_E = 0; branch_E = 0;
        regwrite_M = 0; regwrite_W = 0; mem_busy_M = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        mem_busy_M = 1; mul_start_E = 1; branch_E = 1;
        regwrite_M = 1; rd_M = 7; rs1_E = 7; regwrite_W = 1; rd_W = 9; rs2_E = 9;
        tick();
        #1;
        checks++;
        if (ctl !== 8'b0000_1111) begin
            errors++; $display("FAIL reset_ctl: got %b want %b", ctl, 8'b0000_1111);
        end
        checks++;
        if (fwdA_E !== 2'b00 || fwdB_E !== 2'b00) begin
            errors++; $display("FAIL reset_fwd: got %b/%b want 00/00", fwdA_E, fwdB_E);
        end
        checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_state: got state %0d cnt %0d want 0 0", state, stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        memread_E = 1; rd_E = 5; rs1_D = 5;
        #1;
        checks++;
        if (ctl !== 8'b1100_0100) begin
            errors++; $display("FAIL load_use_ctl: got %b want %b", ctl, 8'b1100_0100);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (ctl !== 8'b0000_0000 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_after: got ctl %b cnt %0d want 00000000 1", ctl, stall_cnt);
        end
        rd_E = 0; memread_E = 1; rs1_D = 0;
        #1;
        checks++;
        if (ctl !== 8'b0000_0000) begin
            errors++; $display("FAIL load_use_r0: got %b want 00000000", ctl);
        end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        do_reset();
        regwrite_M = 1; rd_M = 3; regwrite_W = 1; rd_W = 3; rs1_E = 3; rs2_E = 0;
        #1;
        checks++;
        if (fwdA_E !== 2'b10 || fwdB_E !== 2'b00) begin
            errors++; $display("FAIL fwd_m: got %b/%b want 10/00", fwdA_E, fwdB_E);
        end
        rd_M = 0;
        #1;
        checks++;
        if (fwdA_E !== 2'b01) begin
            errors++; $display("FAIL fwd_w: got %b want 01", fwdA_E);
        end
        rd_M = 4; rs2_E = 4; regwrite_M = 0;
        #1;
        checks++;
        if (fwdA_E !== 2'b01 || fwdB_E !== 2'b00) begin
            errors++; $display("FAIL fwd_nowrite: got %b/%b want 01/00", fwdA_E, fwdB_E);
        end
        regwrite_M = 1;
        #1;
        checks++;
        if (fwdB_E !== 2'b10) begin
            errors++; $display("FAIL fwd_b: got %b want 10", fwdB_E);
        end
        clear_inputs();
    endtask

    task automatic test_mul();
        logic [1:0] es [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        logic [7:0] ec [6] = '{8'b1110_0010, 8'b1110_0010, 8'b1110_0010, 8'b1110_0010, 8'h00, 8'h00};
        do_reset();
        mul_start_E = 1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) mul_start_E = 0;
            #1;
            checks++;
            if (state !== es[k] || ctl !== ec[k]) begin
                errors++; $display("FAIL mul_seq cyc %0d: got state %0d ctl %b want %0d %b", k, state, ctl, es[k], ec[k]);
            end
            if (k < 5) tick();
        end
        checks++;
        if (stall_cnt !== 16'd4) begin
            errors++; $display("FAIL mul_stall_cnt: got %0d want 4", stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        do_reset();
        branch_E = 1; memread_E = 1; rd_E = 5; rs2_D = 5; mul_start_E = 1;
        #1;
        checks++;
        if (ctl !== 8'b0000_1100) begin
            errors++; $display("FAIL branch_ctl: got %b want %b", ctl, 8'b0000_1100);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL branch_after: got state %0d cnt %0d want 0 0", state, stall_cnt);
        end
    endtask

    task automatic test_mem_busy_in_mul();
        logic       bz [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        logic [1:0] es [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        logic [7:0] ec [9] = '{8'b1110_0010, 8'b1110_0010, 8'b1111_0001, 8'b1111_0001,
                              8'b1111_0001, 8'b1110_0010, 8'b1110_0010, 8'h00, 8'h00};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            mul_start_E = (k == 0);
            mem_busy_M  = bz[k];
            #1;
            checks++;
            if (state !== es[k] || ctl !== ec[k]) begin
                errors++; $display("FAIL mem_in_mul cyc %0d: got state %0d ctl %b want %0d %b", k, state, ctl, es[k], ec[k]);
            end
            if (k < 8) tick();
        end
        checks++;
        if (stall_cnt !== 16'd7) begin
            errors++; $display("FAIL mem_in_mul_cnt: got %0d want 7", stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        mul_start_E = 1;
        tick();
        tick();
        rst = 1; regwrite_M = 1; rd_M = 2; rs1_E = 2;
        #1;
        checks++;
        if (ctl !== 8'b0000_1111 || fwdA_E !== 2'b00) begin
            errors++; $display("FAIL rst_mid_mul_ctl: got %b fwd %b want 00001111 00", ctl, fwdA_E);
        end
        tick();
        rst = 0;
        clear_inputs();
        #1;
        checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd0 || ctl !== 8'h00) begin
            errors++; $display("FAIL rst_mid_mul_after: got state %0d cnt %0d ctl %b want 0 0 00000000", state, stall_cnt, ctl);
        end
        tick();
        #1;
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("FAIL rst_mid_mul_run: got state %0d want 0", state);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy_M = 1;
        for (int k = 0; k < 65540; k++) tick();
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL stall_cnt_sat: got %h want ffff", stall_cnt);
        end
        tick();
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL stall_cnt_nowrap: got %h want ffff", stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(0, 99) < 2);
            mem_busy_M  = ($urandom_range(0, 99) < 12);
            branch_E    = ($urandom_range(0, 99) < 10);
            memread_E   = ($urandom_range(0, 99) < 35);
            mul_start_E = ($urandom_range(0, 99) < 15);
            regwrite_E  = 1'($urandom);
            regwrite_M  = 1'($urandom);
            regwrite_W  = 1'($urandom);
            rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
            rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
            rd_E  = 5'($urandom_range(0, 3)); rd_M  = 5'($urandom_range(0, 3));
            rd_W  = 5'($urandom_range(0, 3));
            #1;
            checks++;
            if (ctl !== exp_ctl || fwdA_E !== exp_fwdA || fwdB_E !== exp_fwdB ||
                state !== m_mode[1:0] || stall_cnt !== m_sc) begin
                errors++;
                $display("FAIL random cyc %0d: got ctl %b fwd %b/%b state %0d cnt %0d want %b %b/%b %0d %0d",
                         k, ctl, fwdA_E, fwdB_E, state, stall_cnt, exp_ctl, exp_fwdA, exp_fwdB, m_mode, m_sc);
            end
            tick();
        end
        clear_inputs();
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_forwarding();
        test_mul();
        test_branch_priority();
        test_mem_busy_in_mul();
        test_reset_mid_mul();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
